alu_operand_collector: RTL and testbench

ALU_OPERAND_COLLECTOR -- requirements
Module: alu_operand_collector

---
 rtl/alu_collect_pkg.sv | 36 +++
 rtl/alu_collect_timer.sv | 26 ++
 rtl/alu_operand_collector.sv | 141 ++++++++++++++
 tb/tb_alu_operand_collector.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_collect_pkg.sv
// Shared types and command codes for the ALU operand collector, its ALU and its bench.
// needs_both() decides whether a command waits for both operands before issue.
package alu_collect_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_A = 2'd1,
        WAIT_B = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_AB   = 2'b11;

    // Arithmetic (mode=1) command range boundaries
    localparam int CMD_ADD     = 0;
    localparam int CMD_SUB_CIN = 3;
    localparam int CMD_CMP     = 8;
    localparam int CMD_MUL_SHL = 10;

    // Logic (mode=0) command range boundaries
    localparam int CMD_AND  = 0;
    localparam int CMD_XNOR = 5;
    localparam int CMD_ROL  = 12;
    localparam int CMD_ROR  = 13;

    function automatic logic needs_both(input logic mode, input int cmd);
        if (mode)
            return (cmd inside {[CMD_ADD:CMD_SUB_CIN], [CMD_CMP:CMD_MUL_SHL]});
        else
            return (cmd inside {[CMD_AND:CMD_XNOR], CMD_ROL, CMD_ROR});
    endfunction

endpackage

// File: rtl/alu_collect_timer.sv
// Wait-state age counter: expire is high during the last waiting cycle (count TIMEOUT-1).
// Only instantiated when ALU_COLLECT_TIMEOUT_EN is defined.
module alu_collect_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable)
            count <= count + TW'(1);
    end

    assign expire = enable && (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_operand_collector.sv
// Collects opa/opb beats into one registered ALU command; partial commands may time out.
// Optional timeout behaviour is enabled by defining ALU_COLLECT_TIMEOUT_EN.
module alu_operand_collector
    import alu_collect_pkg::*;
#(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic          in_ready,
    input  logic [1:0]    inp_valid,
    input  logic          mode,
    input  logic [CW-1:0] cmd,
    input  logic          cin,
    input  logic [DW-1:0] opa,
    input  logic [DW-1:0] opb,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    alu_inp_valid,
    output logic          alu_mode,
    output logic [CW-1:0] alu_cmd,
    output logic          alu_cin,
    output logic [DW-1:0] alu_opa,
    output logic [DW-1:0] alu_opb,
    output logic          timeout_err,
    output logic [1:0]    dbg_state
);

    // Handshakes: an input beat transfers when ce && in_ready; a command transfers
    // when out_valid && out_ready, and the alu_* outputs hold steady until then.
    state_t     state, state_next;
    logic       accept, both, expire, timed_out;
    logic       ld_fields, ld_a, ld_b;
    logic [1:0] iv_next;

    assign accept    = ce && in_ready;
    assign both      = needs_both(mode, int'(cmd));
    assign in_ready  = (state != ISSUE);
    assign out_valid = (state == ISSUE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        ld_fields  = 1'b0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        iv_next    = alu_inp_valid;
        timed_out  = 1'b0;
        case (state)
            IDLE: if (accept) begin
                ld_fields = 1'b1;
                if (both && inp_valid == IV_A) begin
                    ld_a = 1'b1; iv_next = IV_A; state_next = WAIT_B;
                end else if (both && inp_valid == IV_B) begin
                    ld_b = 1'b1; iv_next = IV_B; state_next = WAIT_A;
                end else begin
                    ld_a = 1'b1; ld_b = 1'b1; iv_next = inp_valid; state_next = ISSUE;
                end
            end
            // A completing beat takes priority over an expiring timer
            WAIT_B: begin
                if (accept && inp_valid == IV_B) begin
                    ld_b = 1'b1; iv_next = IV_AB; state_next = ISSUE;
                end else if (accept && inp_valid == IV_AB) begin
                    ld_fields = 1'b1; ld_a = 1'b1; ld_b = 1'b1;
                    iv_next = IV_AB; state_next = ISSUE;
                end else if (accept && inp_valid == IV_A) begin
                    ld_fields = 1'b1; ld_a = 1'b1;
                end else if (expire) begin
                    timed_out = 1'b1; state_next = ISSUE;
                end
            end
            WAIT_A: begin
                if (accept && inp_valid == IV_A) begin
                    ld_a = 1'b1; iv_next = IV_AB; state_next = ISSUE;
                end else if (accept && inp_valid == IV_AB) begin
                    ld_fields = 1'b1; ld_a = 1'b1; ld_b = 1'b1;
                    iv_next = IV_AB; state_next = ISSUE;
                end else if (accept && inp_valid == IV_B) begin
                    ld_fields = 1'b1; ld_b = 1'b1;
                end else if (expire) begin
                    timed_out = 1'b1; state_next = ISSUE;
                end
            end
            ISSUE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_inp_valid <= IV_NONE;
            alu_mode      <= 1'b0;
            alu_cmd       <= '0;
            alu_cin       <= 1'b0;
            alu_opa       <= '0;
            alu_opb       <= '0;
            timeout_err   <= 1'b0;
        end else begin
            alu_inp_valid <= iv_next;
            timeout_err   <= timed_out;
            if (ld_fields) begin
                alu_mode <= mode;
                alu_cmd  <= cmd;
                alu_cin  <= cin;
            end
            if (ld_a) alu_opa <= opa;
            if (ld_b) alu_opb <= opb;
        end
    end

`ifdef ALU_COLLECT_TIMEOUT_EN
    logic in_wait, restart;

    // Re-sending the held operand refreshes the pending command and its age
    assign in_wait = (state == WAIT_A) || (state == WAIT_B);
    assign restart = accept && (((state == WAIT_B) && (inp_valid == IV_A)) ||
                                ((state == WAIT_A) && (inp_valid == IV_B)));

    alu_collect_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_wait || restart),
        .enable (in_wait),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_collector.sv
// Bench for alu_operand_collector: vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_alu_operand_collector;
    import alu_collect_pkg::*;

    localparam int TO = 16;

    logic       clk, rst, ce, in_ready, mode, cin, out_valid, out_ready;
    logic       alu_mode, alu_cin, timeout_err;
    logic [1:0] inp_valid, alu_inp_valid, dbg_state;
    logic [3:0] cmd, alu_cmd;
    logic [7:0] opa, opb, alu_opa, alu_opb;

    int checks = 0;
    int errors = 0;

    alu_operand_collector #(.DW(8), .CW(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ce(ce), .in_ready(in_ready), .inp_valid(inp_valid),
        .mode(mode), .cmd(cmd), .cin(cin), .opa(opa), .opb(opb),
        .out_valid(out_valid), .out_ready(out_ready), .alu_inp_valid(alu_inp_valid),
        .alu_mode(alu_mode), .alu_cmd(alu_cmd), .alu_cin(alu_cin), .alu_opa(alu_opa),
        .alu_opb(alu_opb), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic beat(input logic m, input logic [3:0] c, input logic ci,
                        input logic [1:0] v, input logic [7:0] a, input logic [7:0] b);
        ce = 1'b1; mode = m; cmd = c; cin = ci; inp_valid = v; opa = a; opb = b;
        tick();
        ce = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending command tracked as a set of held operands plus its age in cycles.
    logic       m_issuing, m_terr, m_mode, m_cin;
    logic [1:0] m_held, m_iv;
    logic [3:0] m_cmd;
    logic [7:0] m_a, m_b;
    int         m_age;

    function automatic logic ref_both(input logic md, input logic [3:0] c);
        logic [15:0] two_op_set;
        two_op_set = md ? 16'h070F : 16'h303F;
        return two_op_set[c];
    endfunction

    task automatic model_step(input logic r, input logic c_e, input logic [1:0] v,
                              input logic md, input logic [3:0] c, input logic ci,
                              input logic [7:0] a, input logic [7:0] b, input logic ordy);
        if (r) begin
            m_issuing = 0; m_terr = 0; m_held = 0; m_age = 0; m_iv = 0;
            m_mode = 0; m_cmd = 0; m_cin = 0; m_a = 0; m_b = 0;
        end else begin
            m_terr = 0;
            if (m_issuing) begin
                if (ordy) m_issuing = 0;
            end else if (m_held == 2'b00) begin
                if (c_e) begin
                    m_mode = md; m_cmd = c; m_cin = ci;
                    if (ref_both(md, c) && (v == 2'b01 || v == 2'b10)) begin
                        m_held = v; m_iv = v; m_age = 0;
                        if (v[0]) m_a = a; else m_b = b;
                    end else begin
                        m_iv = v; m_a = a; m_b = b; m_issuing = 1;
                    end
                end
            end else begin
                if (c_e && v == ~m_held) begin
                    if (v[0]) m_a = a; else m_b = b;
                    m_iv = 2'b11; m_held = 0; m_issuing = 1;
                end else if (c_e && v == 2'b11) begin
                    m_mode = md; m_cmd = c; m_cin = ci; m_a = a; m_b = b;
                    m_iv = 2'b11; m_held = 0; m_issuing = 1;
                end else if (c_e && v == m_held) begin
                    m_mode = md; m_cmd = c; m_cin = ci; m_age = 0;
                    if (v[0]) m_a = a; else m_b = b;
                end else begin
`ifdef ALU_COLLECT_TIMEOUT_EN
                    if (m_age == TO - 1) begin
                        m_issuing = 1; m_terr = 1; m_held = 0;
                    end else begin
                        m_age++;
                    end
`endif
                end
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       mode;
        logic [3:0] cmd;
        logic       cin;
        logic [1:0] iv;
        logic [7:0] a;
        logic [7:0] b;
        logic       exp_issue;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vt[10];

    int   n;
    logic seen;
    int   ce_pct;
    logic r_rst, r_ce, r_mode, r_cin, r_ordy;
    logic [1:0] r_iv;
    logic [3:0] r_cmd;
    logic [7:0] r_a, r_b;

    initial begin
        rst = 1'b0; ce = 1'b0; out_ready = 1'b0; inp_valid = 2'b00;
        mode = 1'b0; cmd = 4'd0; cin = 1'b0; opa = 8'h00; opb = 8'h00;

        vt[0] = '{1'b1, 4'd0,  1'b0, 2'b11, 8'h12, 8'h34, 1'b1, ISSUE};
        vt[1] = '{1'b0, 4'd2,  1'b0, 2'b00, 8'hAA, 8'h55, 1'b1, ISSUE};
        vt[2] = '{1'b1, 4'd4,  1'b1, 2'b01, 8'h7F, 8'h00, 1'b1, ISSUE};
        vt[3] = '{1'b0, 4'd6,  1'b0, 2'b10, 8'h00, 8'h81, 1'b1, ISSUE};
        vt[4] = '{1'b1, 4'd9,  1'b0, 2'b01, 8'h3C, 8'h00, 1'b0, WAIT_B};
        vt[5] = '{1'b0, 4'd13, 1'b1, 2'b10, 8'h00, 8'hE7, 1'b0, WAIT_A};
        vt[6] = '{1'b1, 4'd11, 1'b0, 2'b10, 8'h00, 8'h19, 1'b1, ISSUE};
        vt[7] = '{1'b0, 4'd7,  1'b1, 2'b01, 8'hC4, 8'h00, 1'b1, ISSUE};
        vt[8] = '{1'b1, 4'd3,  1'b1, 2'b10, 8'h00, 8'h66, 1'b0, WAIT_A};
        vt[9] = '{1'b0, 4'd14, 1'b0, 2'b01, 8'h0F, 8'h00, 1'b1, ISSUE};

        // Reset in the middle of an issue must clear everything
        do_reset();
        beat(1'b1, 4'd5, 1'b1, 2'b11, 8'hF1, 8'hF2);
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_state", dbg_state, IDLE);
        check("rst_alu_iv", alu_inp_valid, 0);
        check("rst_alu_fields", {alu_mode, alu_cmd, alu_cin}, 0);
        check("rst_alu_ops", {alu_opa, alu_opb}, 0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            beat(vt[i].mode, vt[i].cmd, vt[i].cin, vt[i].iv, vt[i].a, vt[i].b);
            check("tbl_out_valid", out_valid, vt[i].exp_issue);
            check("tbl_in_ready", in_ready, !vt[i].exp_issue);
            check("tbl_state", dbg_state, vt[i].exp_state);
            check("tbl_fields", {alu_mode, alu_cmd, alu_cin}, {vt[i].mode, vt[i].cmd, vt[i].cin});
            if (vt[i].exp_issue) check("tbl_iv", alu_inp_valid, vt[i].iv);
            if (vt[i].iv[0]) check("tbl_opa", alu_opa, vt[i].a);
            if (vt[i].iv[1]) check("tbl_opb", alu_opb, vt[i].b);
        end

        // Two-beat completion after idle gap
        do_reset();
        beat(1'b1, 4'd0, 1'b0, 2'b01, 8'h05, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("split_wait_no_issue", out_valid, 0);
        end
        beat(1'b1, 4'd0, 1'b0, 2'b10, 8'h00, 8'h07);
        check("split_out_valid", out_valid, 1);
        check("split_iv", alu_inp_valid, 2'b11);
        check("split_ops", {alu_opa, alu_opb}, 16'h0507);
        check("split_no_timeout", timeout_err, 0);

        // Missing second operand: timeout issue or indefinite wait
        do_reset();
        beat(1'b0, 4'd1, 1'b0, 2'b10, 8'h00, 8'h5A);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
`ifdef ALU_COLLECT_TIMEOUT_EN
        check("to_latency", n, TO);
        check("to_iv", alu_inp_valid, 2'b10);
        check("to_opb", alu_opb, 8'h5A);
        check("to_err_pulse", timeout_err, 1);
        tick();
        check("to_err_one_cycle", timeout_err, 0);
        check("to_still_valid", out_valid, 1);
`else
        check("noto_waiting", out_valid, 0);
        check("noto_err", timeout_err, 0);
        check("noto_state", dbg_state, WAIT_A);
`endif

        // Completion in the same cycle the timer would expire
        do_reset();
        beat(1'b1, 4'd1, 1'b0, 2'b01, 8'h21, 8'h00);
        repeat (TO - 1) tick();
        check("race_not_yet", out_valid, 0);
        beat(1'b1, 4'd1, 1'b0, 2'b10, 8'h00, 8'h43);
        check("race_out_valid", out_valid, 1);
        check("race_iv", alu_inp_valid, 2'b11);
        check("race_no_err", timeout_err, 0);
        check("race_ops", {alu_opa, alu_opb}, 16'h2143);

        // Backpressure: outputs hold, beats dropped
        do_reset();
        beat(1'b1, 4'd0, 1'b1, 2'b11, 8'h3C, 8'hC3);
        for (int i = 0; i < 5; i++) begin
            ce = 1'b1; inp_valid = 2'($urandom_range(0, 3)); mode = 1'($urandom);
            cmd = 4'($urandom); cin = 1'($urandom); opa = 8'($urandom); opb = 8'($urandom);
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold", {alu_inp_valid, alu_mode, alu_cmd, alu_cin, alu_opa, alu_opb},
                  {2'b11, 1'b1, 4'd0, 1'b1, 8'h3C, 8'hC3});
        end
        ce = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_dropped", out_valid, 0);

        // Reset during a wait discards the partial command
        do_reset();
        beat(1'b1, 4'd0, 1'b0, 2'b01, 8'h99, 8'h00);
        repeat (8) tick();
        do_reset();
        check("rstw_state", dbg_state, IDLE);
        check("rstw_out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen = seen | out_valid | timeout_err;
        end
        check("rstw_no_issue", seen, 0);

        // Randomized run against the reference model
        do_reset();
        model_step(1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            ce_pct = ((cyc / 400) % 2 == 0) ? 60 : 4;
            r_rst  = ($urandom_range(0, 299) == 0);
            r_ce   = ($urandom_range(0, 99) < ce_pct);
            r_iv   = 2'($urandom_range(0, 3));
            r_mode = 1'($urandom);
            r_cmd  = 4'($urandom);
            r_cin  = 1'($urandom);
            r_a    = 8'($urandom);
            r_b    = 8'($urandom);
            r_ordy = ($urandom_range(0, 1) == 1);
            rst = r_rst; ce = r_ce; inp_valid = r_iv; mode = r_mode; cmd = r_cmd;
            cin = r_cin; opa = r_a; opb = r_b; out_ready = r_ordy;
            model_step(r_rst, r_ce, r_iv, r_mode, r_cmd, r_cin, r_a, r_b, r_ordy);
            tick();
            check("rnd_out_valid", out_valid, m_issuing);
            check("rnd_in_ready", in_ready, !m_issuing);
            check("rnd_timeout_err", timeout_err, m_terr);
            if (m_issuing) begin
                check("rnd_iv", alu_inp_valid, m_iv);
                check("rnd_fields", {alu_mode, alu_cmd, alu_cin}, {m_mode, m_cmd, m_cin});
                if (m_iv[0]) check("rnd_opa", alu_opa, m_a);
                if (m_iv[1]) check("rnd_opb", alu_opb, m_b);
            end
        end
        rst = 1'b0; ce = 1'b0; out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
